shift_rows_serial: RTL and testbench
====================================

Name: shift_rows_serial

Overview:
- Byte-serial AES ShiftRows stage; sits directly upstream of the byte-serial MixColumns stage and feeds it one byte per cycle.
- Buffers a 16-byte state block in column-major order in a two-bank ping-pong buffer, so one bank fills while the other drains. Sustained throughput is 1 byte/cycle.
- Emits the row-shifted state in column-major order. Alongside each byte it emits the per-column accumulate mask that MixColumns consumes on its `enable` input.

Parameters:
- INVERSE, 0: 0 = ShiftRows (encrypt); 1 = InvShiftRows (decrypt). Elaboration-time only.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all buffered data
- in_byte  in  8  input state byte, column-major (index = 4*col + row)
- in_valid  in  1  in_byte valid
- in_ready  out  1  stage can accept in_byte this cycle
- out_byte  out  8  shifted state byte, column-major
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts out_byte this cycle
- out_last  out  1  out_byte is byte 15 of the block
- out_col_mask  out  8  8'h00 on the first byte of each column (row 0), else 8'hFF; drives MixColumns enable

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Storage: bank[2][16] of 8-bit registers; wr_bank, rd_bank (1 bit each); wr_ptr, rd_ptr (4 bits each); full[1:0].
- Reset values: all bank bytes 0; pointers 0; wr_bank = rd_bank = 0; full = 0.
  - Resulting outputs: in_ready = 1, out_valid = 0, out_byte = 8'h00, out_last = 0, out_col_mask = 8'h00.
- Handshake signals:
  - in_ready = !full[wr_bank].
  - out_valid = full[rd_bank].
  - Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
  - Data and valid hold while stalled.
- Input fire:
  - bank[wr_bank][wr_ptr] <= in_byte; wr_ptr increments.
  - At wr_ptr == 15: wr_ptr wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- Output mapping:
  - rd_ptr = 4c + r (c = column, r = row).
  - out_byte = bank[rd_bank][r + 4*src], where src = (c + r) mod 4 when INVERSE = 0, and src = (c - r) mod 4 when INVERSE = 1.
  - out_byte is a combinational read of registers; there is no added latency.
  - out_last = (rd_ptr == 15).
  - out_col_mask = (rd_ptr[1:0] == 0) ? 8'h00 : 8'hFF.
- Output fire:
  - rd_ptr increments.
  - At rd_ptr == 15: rd_ptr wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- Latency: the first output byte is valid the cycle after input byte 15 is accepted.
  - A block occupies a bank from its first write until its last read.
- Per-bank state machine: EMPTY -> FILLING (first write) -> FULL (16th write) -> DRAINING (first read) -> EMPTY (16th read).
- Simultaneous events:
  - Input fire and output fire in the same cycle always target different banks: a set requires the bank not full, a clear requires it full. Both updates take effect.
  - Both banks full: in_ready = 0 until the drain of rd_bank completes. in_ready rises the cycle after the final read.
- Flush: synchronous; has priority over any fire in the same cycle.
  - Clears full, both pointers, wr_bank and rd_bank.
  - Bank contents are not cleared.
  - out_valid = 0 the next cycle; a partially filled block is discarded.
- Reset mid-block: the asynchronous rst_n immediately returns all state to reset values; the partial block is lost.
- Values are byte moves only; no arithmetic on data.

Test Plan:
- Encrypt, INVERSE=0: input 00,01,...,0f, out_ready=1 -> output 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
  - out_last only on the 0b beat.
  - out_col_mask 00 on beats 0, 4, 8, 12.
- Decrypt, INVERSE=1: same input -> output 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
- FIPS-197 round 1 vector: input d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> output d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
- Back-to-back: three blocks streamed with in_valid = 1 and out_ready = 1 throughout.
  - in_ready stays 1.
  - Outputs are contiguous after the first 16-cycle fill; 48 input cycles yield 48 output bytes in order.
- Backpressure: out_ready = 0 while two blocks are loaded -> in_ready = 0 after 32 accepts, and out_byte is held stable.
  - Release out_ready -> in_ready returns 1 the cycle after the 16th read.
- Flush or reset mid-fill: pulse flush after 7 bytes, then send a fresh block -> only the fresh block is emitted, correctly shifted.
  - Repeat with rst_n asserted asynchronously mid-drain -> out_valid = 0 immediately and in_ready = 1.

Source files
------------

// File: rtl/shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows stage. A two-bank ping-pong buffer lets one block fill
// while the other drains, emitting the row-shifted state with MixColumns column masks.
module shift_rows_serial #(
    parameter bit INVERSE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] out_col_mask
);

    // Read position 4c+r pulls row r from column (c +/- r) mod 4 of the stored block.
    function automatic logic [3:0] src_addr(input logic [3:0] ptr);
        logic [1:0] col_v;
        logic [1:0] row_v;
        logic [1:0] src_v;
        col_v = ptr[3:2];
        row_v = ptr[1:0];
        if (INVERSE) begin
            src_v = col_v - row_v;
        end else begin
            src_v = col_v + row_v;
        end
        return {src_v, row_v};
    endfunction

    // Row 0 of each column starts a fresh MixColumns accumulation.
    function automatic logic [7:0] col_mask(input logic [3:0] ptr);
        logic [7:0] mask_v;
        if (ptr[1:0] == 2'd0) begin
            mask_v = 8'h00;
        end else begin
            mask_v = 8'hFF;
        end
        return mask_v;
    endfunction

    logic [7:0] bank_r [2][16];
    logic       wr_bank_r;
    logic       rd_bank_r;
    logic [3:0] wr_ptr_r;
    logic [3:0] rd_ptr_r;
    logic [1:0] full_r;

    logic       in_fire_s;
    logic       out_fire_s;
    logic       wr_done_s;
    logic       rd_done_s;
    logic [1:0] full_nxt_s;

    assign in_ready     = !full_r[wr_bank_r];
    assign out_valid    = full_r[rd_bank_r];
    assign in_fire_s    = in_valid & in_ready;
    assign out_fire_s   = out_valid & out_ready;
    assign wr_done_s    = in_fire_s & (wr_ptr_r == 4'd15);
    assign rd_done_s    = out_fire_s & (rd_ptr_r == 4'd15);

    // Data path reads the draining bank directly so a byte leaves the cycle it is addressed.
    assign out_byte     = bank_r[rd_bank_r][src_addr(rd_ptr_r)];
    assign out_last     = (rd_ptr_r == 4'd15);
    assign out_col_mask = col_mask(rd_ptr_r);

    // Next bank-occupancy flags; a completed write and a completed read never hit the same bank.
    always_comb begin
        full_nxt_s = full_r;
        if (wr_done_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s = full_nxt_s;
        end
        if (rd_done_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s = full_nxt_s;
        end
    end

    // Pointer, bank-select and occupancy state; flush drops any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_ptr_r  <= 4'd0;
            rd_ptr_r  <= 4'd0;
            full_r    <= 2'b00;
        end else if (flush) begin
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_ptr_r  <= 4'd0;
            rd_ptr_r  <= 4'd0;
            full_r    <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
            if (in_fire_s) begin
                wr_ptr_r <= wr_ptr_r + 4'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (wr_done_s) begin
                wr_bank_r <= ~wr_bank_r;
            end else begin
                wr_bank_r <= wr_bank_r;
            end
            if (out_fire_s) begin
                rd_ptr_r <= rd_ptr_r + 4'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (rd_done_s) begin
                rd_bank_r <= ~rd_bank_r;
            end else begin
                rd_bank_r <= rd_bank_r;
            end
        end
    end

    // Block storage; contents survive flush, only the bookkeeping is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    bank_r[b][i] <= 8'h00;
                end
            end
        end else if (in_fire_s && !flush) begin
            bank_r[wr_bank_r][wr_ptr_r] <= in_byte;
        end else begin
            bank_r <= bank_r;
        end
    end

endmodule

// File: tb/tb_shift_rows_serial.sv
// Directed bench for shift_rows_serial: encrypt and decrypt instances share stimulus and
// are checked against a byte-level scoreboard plus the known-answer tables.
module tb_shift_rows_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       out_ready;

    logic       enc_in_ready, enc_out_valid, enc_out_last;
    logic [7:0] enc_out_byte, enc_out_col_mask;
    logic       dec_in_ready, dec_out_valid, dec_out_last;
    logic [7:0] dec_out_byte, dec_out_col_mask;

    shift_rows_serial #(.INVERSE(1'b0)) dut_enc (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(enc_in_ready),
        .out_byte(enc_out_byte), .out_valid(enc_out_valid), .out_ready(out_ready),
        .out_last(enc_out_last), .out_col_mask(enc_out_col_mask)
    );

    shift_rows_serial #(.INVERSE(1'b1)) dut_dec (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(dec_in_ready),
        .out_byte(dec_out_byte), .out_valid(dec_out_valid), .out_ready(out_ready),
        .out_last(dec_out_last), .out_col_mask(dec_out_col_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] enc;
        logic [7:0] dec;
        logic [7:0] mask;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] blk[16];
    int         blk_n = 0;
    logic [7:0] log_enc[$];
    logic [7:0] log_dec[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         phase_outs = 0;
    int         first_out_cyc = 0;
    int         last_out_cyc = 0;
    bit         b2b_mon = 1'b0;
    bit         ready_dropped = 1'b0;

    logic [7:0] enc_tab[16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                                8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
    logic [7:0] dec_tab[16] = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                                8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
    logic [7:0] fips_in[16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    logic [7:0] fips_out[16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: predicts on accepted input, compares on accepted output (sampled mid-cycle).
    always @(negedge clk) begin : monitor
        exp_t e;
        int c, r;
        if (!rst_n || flush) begin
            sb.delete();
            blk_n = 0;
        end else begin
            if (enc_out_valid && out_ready) begin
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("enc_byte", {24'd0, enc_out_byte}, {24'd0, e.enc});
                    chk("dec_byte", {24'd0, dec_out_byte}, {24'd0, e.dec});
                    chk("dec_valid", {31'd0, dec_out_valid}, 32'd1);
                    chk("enc_last", {31'd0, enc_out_last}, {31'd0, e.last});
                    chk("dec_last", {31'd0, dec_out_last}, {31'd0, e.last});
                    chk("enc_mask", {24'd0, enc_out_col_mask}, {24'd0, e.mask});
                    chk("dec_mask", {24'd0, dec_out_col_mask}, {24'd0, e.mask});
                end
                log_enc.push_back(enc_out_byte);
                log_dec.push_back(dec_out_byte);
                phase_outs++;
                if (phase_outs == 1) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
            if (b2b_mon && in_valid && !enc_in_ready) ready_dropped = 1'b1;
            if (in_valid && enc_in_ready) begin
                blk[blk_n] = in_byte;
                blk_n++;
                if (blk_n == 16) begin
                    for (int p = 0; p < 16; p++) begin
                        c = p / 4;
                        r = p % 4;
                        e.enc  = blk[4 * ((c + r) % 4) + r];
                        e.dec  = blk[4 * ((c - r + 4) % 4) + r];
                        e.last = (p == 15);
                        e.mask = (r == 0) ? 8'h00 : 8'hFF;
                        sb.push_back(e);
                    end
                    blk_n = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!enc_in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!enc_in_ready) chk("send_timeout", {31'd0, enc_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_done", {31'd0, sb.size() == 0}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] hold_enc, hold_dec;
        int t0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00;
        #2;
        chk("rst_in_ready", {31'd0, enc_in_ready}, 32'd1);
        chk("rst_dec_in_ready", {31'd0, dec_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, enc_out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, enc_out_byte}, 32'd0);
        chk("rst_out_last", {31'd0, enc_out_last}, 32'd0);
        chk("rst_col_mask", {24'd0, enc_out_col_mask}, 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer: 00..0f, both directions, plus first-byte latency
        out_ready = 1'b1;
        log_enc.delete(); log_dec.delete();
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        chk("valid_before_last", {31'd0, enc_out_valid}, 32'd0);
        send_byte(8'h0f);
        chk("latency_valid", {31'd0, enc_out_valid}, 32'd1);
        chk("latency_first", {24'd0, enc_out_byte}, 32'h00);
        drain();
        chk("kat_count", log_enc.size(), 32'd16);
        for (int i = 0; i < 16 && i < log_enc.size(); i++) begin
            chk("kat_enc", {24'd0, log_enc[i]}, {24'd0, enc_tab[i]});
            chk("kat_dec", {24'd0, log_dec[i]}, {24'd0, dec_tab[i]});
        end

        // FIPS-197 round 1 vector
        log_enc.delete(); log_dec.delete();
        for (int i = 0; i < 16; i++) send_byte(fips_in[i]);
        drain();
        chk("fips_count", log_enc.size(), 32'd16);
        for (int i = 0; i < 16 && i < log_enc.size(); i++)
            chk("fips_enc", {24'd0, log_enc[i]}, {24'd0, fips_out[i]});

        // Back-to-back: three blocks with no bubbles
        phase_outs = 0; ready_dropped = 1'b0; b2b_mon = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 48; i++) send_byte(8'($urandom_range(0, 255)));
        chk("b2b_in_cycles", cyc - t0, 32'd48);
        b2b_mon = 1'b0;
        drain();
        chk("b2b_ready_held", {31'd0, ready_dropped}, 32'd0);
        chk("b2b_out_count", phase_outs, 32'd48);
        chk("b2b_contiguous", last_out_cyc - first_out_cyc, 32'd47);

        // Backpressure: two blocks loaded, output stalled
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)));
        chk("bp_in_ready_low", {31'd0, enc_in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, enc_out_valid}, 32'd1);
        hold_enc = enc_out_byte;
        hold_dec = dec_out_byte;
        in_valid = 1'b1; in_byte = 8'h55;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        chk("bp_in_ready_still_low", {31'd0, enc_in_ready}, 32'd0);
        chk("bp_enc_hold", {24'd0, enc_out_byte}, {24'd0, hold_enc});
        chk("bp_dec_hold", {24'd0, dec_out_byte}, {24'd0, hold_dec});
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 15) chk("bp_ready_before_final", {31'd0, enc_in_ready}, 32'd0);
            if (i == 16) chk("bp_ready_after_final", {31'd0, enc_in_ready}, 32'd1);
        end
        drain();

        // Flush mid-fill, then a fresh block
        log_enc.delete(); log_dec.delete();
        for (int i = 0; i < 7; i++) send_byte(8'ha0 + 8'(i));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", {31'd0, enc_out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, enc_in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
        drain();
        chk("flush_out_count", log_enc.size(), 32'd16);

        // Asynchronous reset mid-drain, then a fresh block
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'hc0 + 8'(i));
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, enc_out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, enc_in_ready}, 32'd1);
        chk("arst_out_byte", {24'd0, enc_out_byte}, 32'd0);
        chk("arst_out_last", {31'd0, enc_out_last}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        log_enc.delete(); log_dec.delete();
        for (int i = 0; i < 16; i++) send_byte(8'h70 + 8'(i));
        drain();
        chk("arst_out_count", log_enc.size(), 32'd16);

        chk("sb_empty_end", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
